// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg : shared types and constants for the sequential binary-to-BCD path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } bcd_state_t;

    localparam logic [15:0] BCD_MAX     = 16'd9999;
    localparam logic [15:0] ALL_NINES   = 16'h9999;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

    // 10^n, used to derive the saturation limit for any digit count
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 : single-digit double-dabble corrector (in >= 5 ? in + 3 : in)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : iterative shift-add-3 binary to packed BCD, one bit per clock,
//               saturating to all nines with a one-deep latest-wins queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       i_bin,
    input  logic                  i_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_ovf
);

    localparam int                c_BW    = 4 * DIGITS;
    localparam int                c_CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [c_CW-1:0]   c_LAST  = c_CW'(IN_W - 1);
    localparam logic [63:0]       c_MAX   = pow10(DIGITS) - 64'd1;
    localparam logic [c_BW-1:0]   c_NINES = {DIGITS{4'h9}};

    bcd_state_t        r_state;
    bcd_state_t        w_state_nxt;
    logic [IN_W-1:0]   r_shreg;
    logic [c_BW-1:0]   r_scr;
    logic [c_CW-1:0]   r_cnt;
    logic              r_ovf_nxt;
    logic [IN_W-1:0]   r_pend;
    logic              r_pend_v;
    logic [c_BW-1:0]   r_bcd;
    logic              r_valid;
    logic              r_ovf;

    logic [c_BW-1:0]   w_corr;
    logic [c_BW-1:0]   w_shifted;
    logic              w_done;
    logic              w_start;
    logic [IN_W-1:0]   w_start_val;
    logic              w_start_ovf;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_scr[4*g +: 4]),
                .o_digit (w_corr[4*g +: 4])
            );
        end
    endgenerate

    // Scratch after the final shift is the result; no trailing correction.
    assign w_shifted   = {w_corr[c_BW-2:0], r_shreg[IN_W-1]};
    assign w_done      = (r_state == ST_SHIFT) && (r_cnt == c_LAST);
    assign w_start     = ((r_state == ST_IDLE) && i_valid) ||
                         (w_done && (i_valid || r_pend_v));
    assign w_start_val = i_valid ? i_bin : r_pend;
    assign w_start_ovf = (64'(w_start_val) > c_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_done && !i_valid && !r_pend_v) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_ovf_nxt <= 1'b0;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (r_state == ST_SHIFT) begin
                {r_scr, r_shreg} <= {w_corr[c_BW-2:0], r_shreg, 1'b0};
                r_cnt            <= r_cnt + 1'b1;
            end

            if (w_done) begin
                r_bcd   <= r_ovf_nxt ? c_NINES : w_shifted;
                r_ovf   <= r_ovf_nxt;
                r_valid <= 1'b1;
            end

            // Later assignments win: a new start overrides the shift above.
            if (w_start) begin
                r_shreg   <= w_start_val;
                r_scr     <= '0;
                r_cnt     <= '0;
                r_ovf_nxt <= w_start_ovf;
            end

            // A request arriving on the completion edge supersedes any pending one.
            if (w_done) begin
                r_pend_v <= 1'b0;
            end else if ((r_state == ST_SHIFT) && i_valid) begin
                r_pend   <= i_bin;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign o_bcd   = r_bcd;
    assign o_valid = r_valid;
    assign o_busy  = (r_state == ST_SHIFT);
    assign o_ovf   = r_ovf;

endmodule

`default_nettype wire
